// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - parametrised TFT panel timing generator
// Counter stage -> stage 0 (request/coords) -> stage 1 (sync/DE/RGB), all gated by i_enable.
module tft_timing_gen #(
  parameter int H_SYNC    = 48,
  parameter int H_BP      = 88,
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 32,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 13,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int DE_POL    = 1,
  parameter int CW        = 8,
  parameter int BGR       = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic [3*CW-1:0] i_pixel,
  output logic          o_req,
  output logic [15:0]   o_hpixel,
  output logic [15:0]   o_vpixel,
  output logic          o_frame_start,
  output logic          o_HSYNC,
  output logic          o_VSYNC,
  output logic          o_DE,
  output logic [CW-1:0] o_RED,
  output logic [CW-1:0] o_GREEN,
  output logic [CW-1:0] o_BLUE
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Region bounds kept at 32 bits: the active end may equal TOTAL, which need not fit HW/VW.
  localparam logic [31:0] H_SYNC_END  = 32'(H_SYNC);
  localparam logic [31:0] H_ACT_START = 32'(H_SYNC + H_BP);
  localparam logic [31:0] H_ACT_END   = 32'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [31:0] V_SYNC_END  = 32'(V_SYNC);
  localparam logic [31:0] V_ACT_START = 32'(V_SYNC + V_BP);
  localparam logic [31:0] V_ACT_END   = 32'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   h_ext, v_ext;
  logic          h_wrap;

  logic          hsync_d, vsync_d, h_act, v_act, req_d, fs_d;
  logic [15:0]   hpix_d, vpix_d;

  logic          req_q, fs_q, hs0_q, vs0_q;
  logic [15:0]   hpix_q, vpix_q;
  logic          hs1_q, vs1_q, de1_q;
  logic [CW-1:0] red_q, green_q, blue_q;
  logic [CW-1:0] pix_r, pix_g, pix_b;

  assign h_ext = 32'(h_q);
  assign v_ext = 32'(v_q);

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + HW'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  always_comb begin
    hsync_d = (h_ext < H_SYNC_END);
    vsync_d = (v_ext < V_SYNC_END);
    h_act   = (h_ext >= H_ACT_START) && (h_ext < H_ACT_END);
    v_act   = (v_ext >= V_ACT_START) && (v_ext < V_ACT_END);
    req_d   = h_act && v_act;
    fs_d    = (h_q == '0) && (v_q == '0);
    hpix_d  = hpix_q;
    vpix_d  = vpix_q;
    // Coordinates move only while requesting; elsewhere they hold the last request.
    if (req_d) begin
      hpix_d = 16'(h_ext - H_ACT_START);
      vpix_d = 16'(v_ext - V_ACT_START);
    end
  end

  always_comb begin
    pix_g = i_pixel[2*CW-1:CW];
    if (BGR != 0) begin
      pix_r = i_pixel[3*CW-1:2*CW];
      pix_b = i_pixel[CW-1:0];
    end else begin
      pix_r = i_pixel[CW-1:0];
      pix_b = i_pixel[3*CW-1:2*CW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      hs0_q   <= 1'b0;
      vs0_q   <= 1'b0;
      hpix_q  <= '0;
      vpix_q  <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (i_enable) begin
      h_q     <= h_d;
      v_q     <= v_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
      hs0_q   <= hsync_d;
      vs0_q   <= vsync_d;
      hpix_q  <= hpix_d;
      vpix_q  <= vpix_d;
      hs1_q   <= hs0_q;
      vs1_q   <= vs0_q;
      de1_q   <= req_q;
      // i_pixel answers the request registered on the previous enabled cycle.
      red_q   <= req_q ? pix_r : '0;
      green_q <= req_q ? pix_g : '0;
      blue_q  <= req_q ? pix_b : '0;
    end
  end

  assign o_req         = req_q;
  assign o_frame_start = fs_q;
  assign o_hpixel      = hpix_q;
  assign o_vpixel      = vpix_q;
  assign o_HSYNC       = (HSYNC_POL != 0) ? hs1_q : ~hs1_q;
  assign o_VSYNC       = (VSYNC_POL != 0) ? vs1_q : ~vs1_q;
  assign o_DE          = (DE_POL != 0) ? de1_q : ~de1_q;
  assign o_RED         = red_q;
  assign o_GREEN       = green_q;
  assign o_BLUE        = blue_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// tb/tb_tft_timing_gen.sv - bench for tft_timing_gen: three geometries/polarities against a position-based model
module tb_tft_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] pix;

  logic        req_o[3], fs_o[3], hs_o[3], vs_o[3], de_o[3];
  logic [15:0] hp_o[3], vp_o[3];
  logic [7:0]  r_o[3], g_o[3], b_o[3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tft_timing_gen #(.H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
                   .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .HSYNC_POL(0), .VSYNC_POL(0), .DE_POL(1), .CW(8), .BGR(0)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pixel(pix),
    .o_req(req_o[0]), .o_hpixel(hp_o[0]), .o_vpixel(vp_o[0]), .o_frame_start(fs_o[0]),
    .o_HSYNC(hs_o[0]), .o_VSYNC(vs_o[0]), .o_DE(de_o[0]),
    .o_RED(r_o[0]), .o_GREEN(g_o[0]), .o_BLUE(b_o[0]));

  tft_timing_gen #(.H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
                   .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .HSYNC_POL(1), .VSYNC_POL(1), .DE_POL(0), .CW(8), .BGR(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pixel(pix),
    .o_req(req_o[1]), .o_hpixel(hp_o[1]), .o_vpixel(vp_o[1]), .o_frame_start(fs_o[1]),
    .o_HSYNC(hs_o[1]), .o_VSYNC(vs_o[1]), .o_DE(de_o[1]),
    .o_RED(r_o[1]), .o_GREEN(g_o[1]), .o_BLUE(b_o[1]));

  tft_timing_gen #(.H_SYNC(2), .H_BP(0), .H_ACTIVE(8), .H_FP(2),
                   .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(0),
                   .HSYNC_POL(0), .VSYNC_POL(0), .DE_POL(1), .CW(8), .BGR(0)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pixel(pix),
    .o_req(req_o[2]), .o_hpixel(hp_o[2]), .o_vpixel(vp_o[2]), .o_frame_start(fs_o[2]),
    .o_HSYNC(hs_o[2]), .o_VSYNC(vs_o[2]), .o_DE(de_o[2]),
    .o_RED(r_o[2]), .o_GREEN(g_o[2]), .o_BLUE(b_o[2]));

  typedef struct {
    int hs, hbp, ha, hfp, vs, vbp, va, vfp;
    bit hp, vp, dp, bgr;
  } cfg_t;
  cfg_t cfg[3];

  // Model: everything follows from n, the number of enabled edges since reset.
  int          n;
  logic [15:0] lasth[3], lastv[3];
  logic [23:0] cap;

  function automatic int htot(int c);
    return cfg[c].hs + cfg[c].hbp + cfg[c].ha + cfg[c].hfp;
  endfunction
  function automatic int vtot(int c);
    return cfg[c].vs + cfg[c].vbp + cfg[c].va + cfg[c].vfp;
  endfunction
  function automatic int hpos(int c, int k);
    return (k % (htot(c) * vtot(c))) % htot(c);
  endfunction
  function automatic int vpos(int c, int k);
    return (k % (htot(c) * vtot(c))) / htot(c);
  endfunction
  function automatic bit act(int c, int k);
    int h = hpos(c, k);
    int v = vpos(c, k);
    return (h >= cfg[c].hs + cfg[c].hbp) && (h < cfg[c].hs + cfg[c].hbp + cfg[c].ha) &&
           (v >= cfg[c].vs + cfg[c].vbp) && (v < cfg[c].vs + cfg[c].vbp + cfg[c].va);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (n=%0d t=%0t)", nm, act_v, exp_v, n, $time);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      logic e_req, e_fs, e_hsa, e_vsa, e_dea;
      logic [7:0] e_r, e_g, e_b;
      e_req = 0; e_fs = 0; e_hsa = 0; e_vsa = 0; e_dea = 0;
      e_r = 0; e_g = 0; e_b = 0;
      if (n >= 1) begin
        e_req = act(c, n - 1);
        e_fs  = (hpos(c, n - 1) == 0) && (vpos(c, n - 1) == 0);
      end
      if (n >= 2) begin
        e_hsa = hpos(c, n - 2) < cfg[c].hs;
        e_vsa = vpos(c, n - 2) < cfg[c].vs;
        e_dea = act(c, n - 2);
        if (e_dea) begin
          e_g = cap[15:8];
          e_r = cfg[c].bgr ? cap[23:16] : cap[7:0];
          e_b = cfg[c].bgr ? cap[7:0] : cap[23:16];
        end
      end
      chk($sformatf("d%0d.req", c), 32'(req_o[c]), 32'(e_req));
      chk($sformatf("d%0d.fs", c), 32'(fs_o[c]), 32'(e_fs));
      chk($sformatf("d%0d.hpix", c), 32'(hp_o[c]), 32'(lasth[c]));
      chk($sformatf("d%0d.vpix", c), 32'(vp_o[c]), 32'(lastv[c]));
      chk($sformatf("d%0d.hsync", c), 32'(hs_o[c]), 32'(e_hsa ? cfg[c].hp : !cfg[c].hp));
      chk($sformatf("d%0d.vsync", c), 32'(vs_o[c]), 32'(e_vsa ? cfg[c].vp : !cfg[c].vp));
      chk($sformatf("d%0d.de", c), 32'(de_o[c]), 32'(e_dea ? cfg[c].dp : !cfg[c].dp));
      chk($sformatf("d%0d.rgb", c), {8'h0, r_o[c], g_o[c], b_o[c]}, {8'h0, e_r, e_g, e_b});
    end
  endtask

  // Called at a negedge: drive, advance the model across the posedge, check at the next negedge.
  task automatic step(input logic r, input logic e, input logic [23:0] px);
    rst_n = r;
    en    = e;
    pix   = px;
    @(posedge clk);
    if (!r) begin
      n = 0;
      cap = 0;
      for (int c = 0; c < 3; c++) begin
        lasth[c] = 0;
        lastv[c] = 0;
      end
    end else if (e) begin
      n++;
      cap = px;
      for (int c = 0; c < 3; c++) begin
        if (act(c, n - 1)) begin
          lasth[c] = 16'(hpos(c, n - 1) - cfg[c].hs - cfg[c].hbp);
          lastv[c] = 16'(vpos(c, n - 1) - cfg[c].vs - cfg[c].vbp);
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit r, e;
    bit fs, req, hs, vs, de;
  } vec_t;
  vec_t vt[9];

  logic rq[0:240], dq[0:240], hq[0:240], vq[0:240], fq[0:240], f2[0:240];
  logic h1[0:240], v1[0:240], d1[0:240];

  initial begin
    int cnt, cnt2, cnt3, cnt4, cnt5, t_first, t_second;
    bit found;

    cfg[0] = '{2, 3, 8, 2, 1, 2, 4, 1, 0, 0, 1, 0};
    cfg[1] = '{2, 3, 8, 2, 1, 2, 4, 1, 1, 1, 0, 1};
    cfg[2] = '{2, 0, 8, 2, 1, 2, 4, 0, 0, 0, 1, 0};
    n = 0;
    cap = 0;
    for (int c = 0; c < 3; c++) begin
      lasth[c] = 0;
      lastv[c] = 0;
    end
    rst_n = 0;
    en = 0;
    pix = 0;
    @(negedge clk);

    // Reset, enable gating and the first frame-start pulse for the default geometry.
    vt[0] = '{0, 0, 0, 0, 1, 1, 0};
    vt[1] = '{1, 0, 0, 0, 1, 1, 0};
    vt[2] = '{1, 1, 1, 0, 1, 1, 0};
    vt[3] = '{1, 1, 0, 0, 0, 0, 0};
    vt[4] = '{1, 0, 0, 0, 0, 0, 0};
    vt[5] = '{1, 1, 0, 0, 0, 0, 0};
    vt[6] = '{1, 1, 0, 0, 1, 0, 0};
    vt[7] = '{0, 1, 0, 0, 1, 1, 0};
    vt[8] = '{1, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].r, vt[i].e, 24'($urandom));
      chk($sformatf("vec%0d.fs", i), 32'(fs_o[0]), 32'(vt[i].fs));
      chk($sformatf("vec%0d.req", i), 32'(req_o[0]), 32'(vt[i].req));
      chk($sformatf("vec%0d.hs", i), 32'(hs_o[0]), 32'(vt[i].hs));
      chk($sformatf("vec%0d.vs", i), 32'(vs_o[0]), 32'(vt[i].vs));
      chk($sformatf("vec%0d.de", i), 32'(de_o[0]), 32'(vt[i].de));
    end

    step(0, 1, 24'hffffff);
    chk("rst.d1.hsync", 32'(hs_o[1]), 0);
    chk("rst.d1.vsync", 32'(vs_o[1]), 0);
    chk("rst.d1.de", 32'(de_o[1]), 1);

    // Two frames with i_enable held high.
    for (int t = 1; t <= 240; t++) begin
      step(1, 1, 24'($urandom));
      rq[t] = req_o[0]; dq[t] = de_o[0]; hq[t] = hs_o[0]; vq[t] = vs_o[0];
      fq[t] = fs_o[0]; f2[t] = fs_o[2];
      h1[t] = hs_o[1]; v1[t] = vs_o[1]; d1[t] = de_o[1];
    end
    cnt = 0; cnt2 = 0; cnt3 = 0; cnt4 = 0; cnt5 = 0;
    for (int t = 1; t <= 240; t++) cnt += fq[t];
    chk("frame.fs_count", 32'(cnt), 2);
    chk("frame.fs_t1", 32'(fq[1]), 1);
    chk("frame.fs_t121", 32'(fq[121]), 1);
    cnt = 0;
    for (int t = 1; t <= 120; t++) cnt += rq[t];
    for (int t = 2; t <= 121; t++) begin
      cnt2 += dq[t];
      cnt3 += (hq[t] == 1'b0);
      cnt4 += (vq[t] == 1'b0);
    end
    for (int t = 2; t <= 240; t++) cnt5 += (dq[t] != rq[t-1]);
    chk("frame.req_count", 32'(cnt), 32);
    chk("frame.de_count", 32'(cnt2), 32);
    chk("frame.hsync_low", 32'(cnt3), 16);
    chk("frame.vsync_low", 32'(cnt4), 15);
    chk("frame.de_lag", 32'(cnt5), 0);
    cnt = 0;
    for (int t = 1; t <= 240; t++)
      cnt += (h1[t] == hq[t]) + (v1[t] == vq[t]) + (d1[t] == dq[t]);
    chk("frame.inverted", 32'(cnt), 0);
    cnt = 0;
    for (int t = 1; t <= 240; t++) cnt += f2[t];
    chk("zp.fs_count", 32'(cnt), 3);
    chk("zp.fs_t85", 32'(f2[85]), 1);

    // Echo the requested coordinate back as pixel data.
    step(0, 1, 0);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      pix = {12'h0, vp_o[0][3:0], hp_o[0][7:0]};
      if (req_o[0] && hp_o[0] == 16'd5 && vp_o[0] == 16'd2) begin
        step(1, 1, pix);
        chk("echo.d0.red", 32'(r_o[0]), 5);
        chk("echo.d0.green", 32'(g_o[0]), 2);
        chk("echo.d0.blue", 32'(b_o[0]), 0);
        chk("echo.d1.blue", 32'(b_o[1]), 5);
        chk("echo.d1.red", 32'(r_o[1]), 0);
        found = 1;
        break;
      end
      step(1, 1, pix);
    end
    chk("echo.found", 32'(found), 1);

    // Enable toggling doubles the frame period.
    step(0, 1, 0);
    t_first = -1;
    t_second = -1;
    for (int t = 1; t <= 500; t++) begin
      step(1, (t % 2) == 1, 24'($urandom));
      if ((t % 2) == 1 && fs_o[0]) begin
        if (t_first < 0) t_first = t;
        else if (t_second < 0) t_second = t;
      end
    end
    chk("toggle.first_fs", 32'(t_first), 1);
    chk("toggle.period", 32'(t_second - t_first), 240);

    // Reset while DE is active, then one clean frame.
    step(0, 1, 0);
    for (int i = 0; i < 67; i++) step(1, 1, 24'($urandom));
    chk("midrst.de_before", 32'(de_o[0]), 1);
    step(0, 1, 24'($urandom));
    chk("midrst.de", 32'(de_o[0]), 0);
    chk("midrst.rgb", {8'h0, r_o[0], g_o[0], b_o[0]}, 0);
    step(1, 1, 24'($urandom));
    chk("midrst.fs", 32'(fs_o[0]), 1);
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      step(1, 1, 24'($urandom));
      cnt += de_o[0];
    end
    chk("midrst.de_count", 32'(cnt), 32);

    // Random enable, pixel data and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           24'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
